cv_channel_accum: RTL and testbench

Parametrised multi-channel accumulation stage for the convolution engine. Takes per-channel partial output columns from upstream `cv3_filter` instances and reduces them through a pipelined fp16 adder tree. Accumulates over several time-multiplexed channel groups, adds a bias, optionally applies ReLU, and presents one output column per layer position under a valid/ready handshake. It generalises the fixed 4-channel, 3-stage channel summer so that channel count exceeds physical lanes and downstream can stall.

---
 rtl/cv_channel_accum.sv | 187 ++++++++++++++++++
 tb/tb_cv_channel_accum.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_channel_accum.sv
// Multi-channel fp16 accumulator: adder tree, group accumulation, bias, optional ReLU (CV_CHANNEL_RELU_EN).
// Latency: TREE_DEPTH+1 cycles from the last beat of a column to out_valid.
// Backpressure: out_valid && !out_ready freezes the whole pipeline and drops in_ready.
module cv_channel_accum #(
    parameter int          DATA_WIDTH        = 16,
    parameter int          KERNEL_SIZE       = 3,
    parameter int          INPUT_COL_SIZE    = 12,
    parameter int          CHANNELS_PER_BEAT = 4,
    parameter int          CHANNEL_GROUPS    = 2,
    parameter logic [15:0] BIAS              = 16'hb06a,
    localparam int         PARALLEL_UNITS    = INPUT_COL_SIZE - KERNEL_SIZE + 1,
    localparam int         GRP_W             = (CHANNEL_GROUPS > 1) ? $clog2(CHANNEL_GROUPS) : 1
) (
    input  logic                                                          clk,
    input  logic                                                          rst_n,
    input  logic                                                          acc_clear,
    input  logic                                                          in_valid,
    output logic                                                          in_ready,
    input  logic [CHANNELS_PER_BEAT-1:0][PARALLEL_UNITS-1:0][DATA_WIDTH-1:0] partial_columns,
    output logic                                                          out_valid,
    input  logic                                                          out_ready,
    output logic [PARALLEL_UNITS-1:0][DATA_WIDTH-1:0]                     out_column,
    output logic [GRP_W-1:0]                                              grp_idx
);
    localparam int CPB        = CHANNELS_PER_BEAT;
    localparam int PU         = PARALLEL_UNITS;
    localparam int DW         = DATA_WIDTH;
    localparam int TREE_DEPTH = $clog2(CHANNELS_PER_BEAT);
    localparam int NODES      = 2 * CHANNELS_PER_BEAT;

    // IEEE fp16 add, round-to-nearest-even, subnormals supported, canonical NaN 16'h7e00.
    function automatic logic [15:0] addfp16(input logic [15:0] a, input logic [15:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, sub, rnd;
        logic [15:0] x, y;
        logic [4:0]  ex, ey;
        logic [10:0] mx, my;
        logic [31:0] sh;
        logic [13:0] al, xa, s;
        logic [14:0] sum;
        logic [5:0]  er, ef;
        logic [11:0] m12;
        logic [9:0]  frac;
        a_nan = (&a[14:10]) && (|a[9:0]);
        b_nan = (&b[14:10]) && (|b[9:0]);
        a_inf = (&a[14:10]) && !(|a[9:0]);
        b_inf = (&b[14:10]) && !(|b[9:0]);
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return 16'h7e00;
        if (a_inf) return a;
        if (b_inf) return b;
        x   = (a[14:0] >= b[14:0]) ? a : b;
        y   = (a[14:0] >= b[14:0]) ? b : a;
        ex  = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey  = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx  = {|x[14:10], x[9:0]};
        my  = {|y[14:10], y[9:0]};
        sh  = {my, 21'b0} >> (ex - ey);
        al  = {sh[31:19], sh[18] | (|sh[17:0])};
        xa  = {mx, 3'b0};
        sub = x[15] ^ y[15];
        sum = sub ? ({1'b0, xa} - {1'b0, al}) : ({1'b0, xa} + {1'b0, al});
        if (sum == 15'd0) return {(sub ? 1'b0 : x[15]), 15'd0};
        er = {1'b0, ex};
        if (sum[14]) begin
            s  = {sum[14:2], sum[1] | sum[0]};
            er = er + 6'd1;
        end else begin
            s = sum[13:0];
        end
        for (int i = 0; i < 13; i++) begin
            if (!s[13] && (er > 6'd1)) begin
                s  = {s[12:0], 1'b0};
                er = er - 6'd1;
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        m12 = {1'b0, s[13:3]} + {11'd0, rnd};
        if (m12[11]) begin
            ef   = er + 6'd1;
            frac = m12[10:1];
        end else begin
            ef   = m12[10] ? er : 6'd0;
            frac = m12[9:0];
        end
        if (ef >= 6'd31) return {x[15], 5'h1f, 10'h000};
        return {x[15], ef[4:0], frac};
    endfunction

    function automatic logic [15:0] post_fn(input logic [15:0] v);
`ifdef CV_CHANNEL_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    logic                  w_stall, w_beat, w_fire, w_last;
    logic                  w_stage_vld [0:TREE_DEPTH];
    logic [PU-1:0][DW-1:0] w_node [1:NODES-1];
    logic [PU-1:0][DW-1:0] w_acc_next, w_out_next;
    logic [PU-1:0][DW-1:0] r_acc, r_out_col;
    logic [GRP_W-1:0]      r_grp;
    logic                  r_out_vld;

    assign w_stall        = r_out_vld & ~out_ready;
    assign in_ready       = ~w_stall;
    assign w_beat         = in_valid & ~w_stall & ~acc_clear;
    assign w_stage_vld[0] = w_beat;

    // Heap-ordered tree: node n sums children 2n and 2n+1; nodes >= CPB are the input channels.
    for (genvar n = 1; n < NODES; n++) begin : g_node
        if (n >= CPB) begin : g_leaf
            assign w_node[n] = partial_columns[n - CPB];
        end else begin : g_add
            localparam int STAGE = TREE_DEPTH - ($clog2(n + 1) - 1);
            logic [PU-1:0][DW-1:0] r_sum;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                end else if (!w_stall && w_stage_vld[STAGE-1]) begin
                    for (int l = 0; l < PU; l++) begin
                        r_sum[l] <= addfp16(w_node[2*n][l], w_node[2*n+1][l]);
                    end
                end
            end
            assign w_node[n] = r_sum;
        end
    end

    for (genvar s = 1; s <= TREE_DEPTH; s++) begin : g_vld
        logic r_vld;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
            end else if (acc_clear) begin
                r_vld <= 1'b0;
            end else if (!w_stall) begin
                r_vld <= w_stage_vld[s-1];
            end
        end
        assign w_stage_vld[s] = r_vld;
    end

    assign w_fire = w_stage_vld[TREE_DEPTH] & ~w_stall & ~acc_clear;
    assign w_last = (r_grp == GRP_W'(CHANNEL_GROUPS - 1));

    // Bias enters first, groups follow in arrival order, so the result is order-exact.
    always_comb begin
        w_acc_next = '0;
        w_out_next = '0;
        for (int l = 0; l < PU; l++) begin
            w_acc_next[l] = addfp16((r_grp == '0) ? BIAS : r_acc[l], w_node[1][l]);
            w_out_next[l] = post_fn(w_acc_next[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_grp <= '0;
        end else if (acc_clear) begin
            r_grp <= '0;
        end else if (w_fire) begin
            if (w_last) begin
                r_grp <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_grp <= r_grp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_col <= '0;
        end else if (w_fire && w_last) begin
            r_out_vld <= 1'b1;
            r_out_col <= w_out_next;
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign out_valid  = r_out_vld;
    assign out_column = r_out_col;
    assign grp_idx    = r_grp;
endmodule

// File: tb/tb_cv_channel_accum.sv
// Bench for cv_channel_accum: real-arithmetic fp16 reference model with column scoreboard.
module tb_cv_channel_accum;
    localparam int          CPB  = 4;
    localparam int          G    = 2;
    localparam int          K    = 3;
    localparam int          IC   = 12;
    localparam int          PU   = IC - K + 1;
    localparam logic [15:0] BIAS = 16'hb06a;

    typedef logic [PU-1:0][15:0]          col_t;
    typedef logic [CPB-1:0][PU-1:0][15:0] beat_t;

    logic  clk = 1'b0;
    logic  rst_n, acc_clear, in_valid, in_ready, out_valid, out_ready;
    beat_t partial_columns;
    col_t  out_column;
    logic  grp_idx;

    int    n_chk = 0;
    int    n_err = 0;
    col_t  part_q[$];
    col_t  exp_q[$];
    col_t  last_out;

    cv_channel_accum #(
        .DATA_WIDTH(16), .KERNEL_SIZE(K), .INPUT_COL_SIZE(IC),
        .CHANNELS_PER_BEAT(CPB), .CHANNEL_GROUPS(G), .BIAS(BIAS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .acc_clear(acc_clear), .in_valid(in_valid),
        .in_ready(in_ready), .partial_columns(partial_columns), .out_valid(out_valid),
        .out_ready(out_ready), .out_column(out_column), .grp_idx(grp_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_to_real(input logic [15:0] h);
        real mag;
        if (h[14:10] == 5'd0) mag = real'(h[9:0]) * pow2(-24);
        else mag = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -mag : mag;
    endfunction

    function automatic longint rne(input real v);
        real    f;
        longint i;
        f = $floor(v);
        i = longint'(f);
        if ((v - f > 0.5) || ((v - f == 0.5) && i[0])) i++;
        return i;
    endfunction

    function automatic logic [15:0] real_to_fp(input real x);
        logic   s;
        real    a;
        int     e;
        longint n;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a < pow2(-14)) begin
            n = rne(a * pow2(24));
            return {s, 15'(n)};
        end
        e = -14;
        while (e < 16 && a >= pow2(e + 1)) e++;
        if (e > 15) return {s, 15'h7c00};
        n = rne(a * pow2(10 - e));
        if (n == 2048) begin
            n = 1024;
            e++;
        end
        if (e > 15) return {s, 15'h7c00};
        return {s, 5'(e + 15), 10'(n - 1024)};
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic an, bn, ai, bi;
        real  s;
        an = (a[14:10] == 5'h1f) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1f) && (b[9:0] != 0);
        ai = (a[14:10] == 5'h1f) && (a[9:0] == 0);
        bi = (b[14:10] == 5'h1f) && (b[9:0] == 0);
        if (an || bn || (ai && bi && a[15] != b[15])) return 16'h7e00;
        if (ai) return a;
        if (bi) return b;
        s = fp_to_real(a) + fp_to_real(b);
        if (s == 0.0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
        return real_to_fp(s);
    endfunction

    function automatic logic [15:0] post_fn(input logic [15:0] v);
`ifdef CV_CHANNEL_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic col_t tree_sum(input beat_t d);
        col_t        r;
        logic [15:0] v [CPB];
        for (int l = 0; l < PU; l++) begin
            for (int c = 0; c < CPB; c++) v[c] = d[c][l];
            for (int w = CPB; w > 1; w = w / 2)
                for (int j = 0; j < w / 2; j++) v[j] = fp_add(v[2*j], v[2*j+1]);
            r[l] = v[0];
        end
        return r;
    endfunction

    task automatic model_beat(input beat_t d);
        col_t        r;
        logic [15:0] acc;
        part_q.push_back(tree_sum(d));
        if (part_q.size() == G) begin
            for (int l = 0; l < PU; l++) begin
                acc = BIAS;
                for (int g = 0; g < G; g++) acc = fp_add(acc, part_q[g][l]);
                r[l] = post_fn(acc);
            end
            exp_q.push_back(r);
            part_q.delete();
        end
    endtask

    function automatic logic [15:0] rand_val();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int c = 0; c < CPB; c++)
            for (int l = 0; l < PU; l++) b[c][l] = rand_val();
        return b;
    endfunction

    function automatic beat_t const_beat(input logic [15:0] v);
        beat_t b;
        for (int c = 0; c < CPB; c++)
            for (int l = 0; l < PU; l++) b[c][l] = v;
        return b;
    endfunction

    // One cycle: drive at negedge, observe, then account for the handshakes of the coming edge.
    task automatic step(input logic iv, input beat_t d, input logic ordy, input logic clr,
                        output logic acc);
        @(negedge clk);
        in_valid        = iv;
        partial_columns = d;
        out_ready       = ordy;
        acc_clear       = clr;
        #1;
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
            check("out_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("out_column", out_column, exp_q.pop_front());
            last_out = out_column;
        end
        acc = iv && in_ready && !clr;
        if (clr) part_q.delete();
        if (acc) model_beat(d);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step(1'b0, '0, 1'b1, 1'b0, a);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic  a;
        int    idx;
        beat_t bl [8];
        col_t  e;
        logic [3:0] pat;

        rst_n = 1'b0; acc_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        partial_columns = '0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_column", out_column, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_grp_idx", grp_idx, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two beats of 1.0, then latency and single-cycle pulse of out_valid.
        step(1'b1, const_beat(16'h3c00), 1'b1, 1'b0, a);
        check("basic_acc0", a, 1'b1);
        step(1'b1, const_beat(16'h3c00), 1'b1, 1'b0, a);
        check("basic_acc1", a, 1'b1);
        pat = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, a);
            check($sformatf("latency_c%0d", i + 1), out_valid, pat[i]);
        end
        check("basic_done", exp_q.size(), 0);

        // All-zero input leaves only the bias.
        step(1'b1, const_beat(16'h0000), 1'b1, 1'b0, a);
        step(1'b1, const_beat(16'h0000), 1'b1, 1'b0, a);
        drain();
        for (int l = 0; l < PU; l++) begin
`ifdef CV_CHANNEL_RELU_EN
            e[l] = 16'h0000;
`else
            e[l] = BIAS;
`endif
        end
        check("bias_only", last_out, e);

        // Negative sums.
        step(1'b1, const_beat(16'hbc00), 1'b1, 1'b0, a);
        step(1'b1, const_beat(16'hbc00), 1'b1, 1'b0, a);
        drain();
`ifdef CV_CHANNEL_RELU_EN
        check("relu_lane0", last_out[0], 16'h0000);
`else
        check("neg_sign_lane0", last_out[0][15], 1'b1);
`endif

        // Abort after group 0; a beat presented with acc_clear is dropped.
        step(1'b1, const_beat(16'h4000), 1'b1, 1'b0, a);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, a);
        check("grp_after_g0", grp_idx, 1'b1);
        step(1'b1, const_beat(16'h5555), 1'b1, 1'b1, a);
        check("clr_discard", a, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, a);
        check("grp_after_clr", grp_idx, 1'b0);
        step(1'b1, const_beat(16'h4000), 1'b1, 1'b0, a);
        step(1'b1, const_beat(16'h4000), 1'b1, 1'b0, a);
        drain();

        // Backpressure: four columns with out_ready low for cycles 5..10.
        for (int i = 0; i < 8; i++) bl[i] = rand_beat();
        idx = 0;
        for (int c = 0; c < 80 && idx < 8; c++) begin
            step(1'b1, bl[idx], !(c >= 5 && c <= 10), 1'b0, a);
            if (a) idx++;
        end
        check("bp_all_sent", idx, 8);
        drain();

        // Random traffic with random stalls.
        idx = 0;
        for (int c = 0; c < 2000 && idx < 50; c++) begin
            step($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 3) != 0, 1'b0, a);
            if (a) idx++;
        end
        check("rand_all_sent", idx, 50);
        drain();

        // Reset with a partial column in flight and a column pending at the output.
        step(1'b1, rand_beat(), 1'b0, 1'b0, a);
        step(1'b1, rand_beat(), 1'b0, 1'b0, a);
        step(1'b1, rand_beat(), 1'b0, 1'b0, a);
        for (int i = 0; i < 10 && !out_valid; i++) step(1'b0, '0, 1'b0, 1'b0, a);
        check("rst_pending", out_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_column", out_column, '0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_grp_idx", grp_idx, 1'b0);
        exp_q.delete();
        part_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, rand_beat(), 1'b1, 1'b0, a);
        step(1'b1, rand_beat(), 1'b1, 1'b0, a);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
